edac_secded_pipe: RTL and testbench
===================================

Name: edac_secded_pipe

Overview:
- Parametrised SECDED Hamming encoder/decoder; successor to the fixed 8-bit EDAC block on the core I/O path.
- Two-stage pipeline, one operation accepted per clock.
- Adds saturating corrected/uncorrectable error counters and a status word readable on the same DOUT bus.
- Sits between core data bus and protected memory/IO: encodes on write, checks and corrects on read.

Parameters:
- DATA_W, 8: data bits per word; 2..26.
- P, derived (localparam): smallest P with 2^P >= DATA_W+P+1 (4 for DATA_W=8).
- CW_W, derived (localparam): codeword width DATA_W+P+1 (13 for DATA_W=8).
- BUS_W, 32: DIN/DOUT width; CW_W <= BUS_W required.
- CNT_W, 8: error counter width.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- en  in  1  operation strobe; one operation per cycle while high.
- READ  in  1  1 = decode/check codeword on DIN; 0 = encode data on DIN[DATA_W-1:0].
- EDACSEL  in  1  DOUT select: 1 = result register, 0 = status word.
- clr_cnt  in  1  clear counters and sticky flags.
- DIN  in  BUS_W  data (encode) or codeword (decode); unused upper bits ignored.
- DOUT  out  BUS_W  result or status, zero-extended.
- dout_valid  out  1  result register updated this cycle.
- sec  out  1  result is a corrected single error (valid with dout_valid).
- ded  out  1  result has an uncorrectable double error (valid with dout_valid).

Behaviour:
- Clock and reset: one clock CLK; reset synchronous, active-low. Clock port named CLK, reset port named reset, as elsewhere in the codebase.
- Codeword layout: DIN/DOUT bit i = Hamming position i.
  - Bit 0: overall even parity over positions 1..CW_W-1.
  - Check bits at power-of-two positions.
  - Data bits d0.. fill the remaining positions in ascending order (d0 at position 3).
- Reset value: DOUT = 0, dout_valid = 0, sec = 0, ded = 0. Result register, pipeline valids, counters, flags and syndrome all cleared.
- Reset mid-operation drops in-flight operations; no dout_valid for them.
- Stage 1 (cycle N, en = 1): register DIN and READ; compute syndrome (P bits) and overall parity for decode, or check bits for encode.
- Stage 2 (cycle N+1): form the result; dout_valid = 1 at N+1 after the edge. Latency 2 edges, fully pipelined.
- en = 0 inserts a bubble. The result register holds its last value; dout_valid = 0.
- Decode classification:
  - syndrome = 0, parity even: clean; result = extracted data; sec = 0, ded = 0.
  - parity odd: single error at position = syndrome (0 means the overall bit). Flip that bit, extract data; sec = 1.
  - syndrome != 0, parity even: double error; result = raw extracted data, uncorrected; ded = 1.
  - syndrome pointing beyond CW_W-1 with odd parity: treat as ded.
- Encode result: CW_W-bit codeword in DOUT[CW_W-1:0]; sec = ded = 0; counters untouched.
- Decode result: data in DOUT[DATA_W-1:0].
- Status word (EDACSEL = 0):
  - [CNT_W-1:0] sec_cnt
  - [2*CNT_W-1:CNT_W] ded_cnt
  - [16] sticky_sec
  - [17] sticky_ded
  - [24 +: P] last syndrome (optional feature)
  - other bits 0
- Counters increment at stage 2 on sec/ded and saturate at 2^CNT_W-1, no wrap.
- clr_cnt (synchronous): zeroes counters, sticky flags and syndrome register. If an error event occurs in the same cycle, the counter loads 1 and the flag sets; the event is not lost.
- DOUT is combinational mux of registered sources; EDACSEL may change any cycle.

Optional Feature:
- Macro EDAC_SYND_CAPTURE_EN.
- Defined: status [24 +: P] holds the syndrome of the first sec/ded since reset or clr_cnt. Later errors do not overwrite it.
- Undefined: those bits read 0 and no syndrome register is built.

Test Plan:
- Encode: reset low 1 cycle; en=1, READ=0, DIN=0x000000F4 -> 2 cycles later dout_valid=1, EDACSEL=1 DOUT=0x00001E44, sec=ded=0.
- Clean decode: READ=1, DIN=0x00001E44 -> DOUT=0x000000F4, sec=0, ded=0, counters 0.
- Single-error correction: DIN=0x00001C44 (position 9 flipped) -> DOUT=0x000000F4, sec=1; EDACSEL=0 status [7:0]=1, [16]=1, [27:24]=9 with EDAC_SYND_CAPTURE_EN. Repeat with DIN=0x00001E45 -> 0xF4, sec=1, sec_cnt=2.
- Double error: DIN=0x00001C40 -> DOUT=0x000000E4, ded=1; ded_cnt=1, [17]=1.
- Back-to-back and saturation: 300 consecutive en cycles with DIN=0x00001C44 -> dout_valid high every cycle, sec_cnt stops at 0xFF.
- Clear: clr_cnt=1 in the same cycle as a stage-2 single error -> sec_cnt=1. Reset low mid-stream -> no dout_valid for in-flight ops, all outputs 0.

Source files
------------

// File: rtl/edac_secded_pipe_if.sv
// edac_secded_pipe_if: operation strobe, data bus and result flags of the
// SECDED pipeline. The master drives operations; the slave is the EDAC block.
interface edac_secded_pipe_if #(
  parameter int BUS_W = 32
);
  logic             en;
  logic             READ;
  logic             EDACSEL;
  logic             clr_cnt;
  logic [BUS_W-1:0] DIN;
  logic [BUS_W-1:0] DOUT;
  logic             dout_valid;
  logic             sec;
  logic             ded;

  modport master (
    output en, READ, EDACSEL, clr_cnt, DIN,
    input  DOUT, dout_valid, sec, ded
  );

  modport slave (
    input  en, READ, EDACSEL, clr_cnt, DIN,
    output DOUT, dout_valid, sec, ded
  );
endinterface

// File: rtl/edac_secded_pipe.sv
// edac_secded_pipe: two-stage SECDED Hamming encoder/decoder with saturating
// corrected/uncorrectable error counters and a status word on DOUT.
// Codeword bit i is Hamming position i; bit 0 is overall even parity.
// Build option: define EDAC_SYND_CAPTURE_EN to hold the syndrome of the first
// error since reset/clear in status bits [24 +: P]; otherwise those bits are 0.
module edac_secded_pipe #(
  parameter int DATA_W = 8,
  parameter int BUS_W  = 32,
  parameter int CNT_W  = 8
) (
  input logic               CLK,
  input logic               reset,
  edac_secded_pipe_if.slave bus
);

  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Hamming position of data bit k: k-th non-power-of-two position >= 3.
  function automatic int data_pos(input int k);
    int pos;
    int n;
    pos = 0;
    n   = -1;
    for (int i = 1; i < 64; i++) begin
      if ((i & (i - 1)) != 0) begin
        n++;
        if (n == k && pos == 0) pos = i;
      end
    end
    return pos;
  endfunction

  localparam int P    = calc_p(DATA_W);
  localparam int CW_W = DATA_W + P + 1;

  function automatic logic [P-1:0] hsyn(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) s ^= P'(i);
    end
    return s;
  endfunction

  logic [CW_W-1:0]   din_cw, placed, enc_cw, flip, corr_cw;
  logic [P-1:0]      chk;
  logic [DATA_W-1:0] corr_data;
  logic              s1_valid, s1_read, s1_par;
  logic [CW_W-1:0]   s1_cw;
  logic [P-1:0]      s1_synd;
  logic              in_range, ev_sec, ev_ded;
  logic [BUS_W-1:0]  result_next, result_q, status;
  logic              dout_valid_q, sec_q, ded_q;
  logic [CNT_W-1:0]  sec_cnt, ded_cnt;
  logic              sticky_sec, sticky_ded;
  logic              unused_din;

  assign din_cw     = bus.DIN[CW_W-1:0];
  assign unused_din = ^bus.DIN;

  for (genvar k = 0; k < DATA_W; k++) begin : g_map
    localparam int POS = data_pos(k);
    assign placed[POS]  = bus.DIN[k];
    assign corr_data[k] = corr_cw[POS];
  end

  for (genvar i = 0; i < P; i++) begin : g_chk_slot
    assign placed[1 << i] = 1'b0;
  end
  assign placed[0] = 1'b0;

  assign chk = hsyn(placed);

  // Encoder: drop check bits into power-of-two slots, then overall parity.
  always_comb begin
    enc_cw = placed;
    for (int i = 0; i < P; i++) enc_cw[1 << i] = chk[i];
    enc_cw[0] = ^enc_cw[CW_W-1:1];
  end

  // Stage 1: capture operation with its syndrome/parity or finished codeword.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_cw    <= '0;
      s1_synd  <= '0;
      s1_par   <= 1'b0;
    end else begin
      s1_valid <= bus.en;
      if (bus.en) begin
        s1_read <= bus.READ;
        s1_cw   <= bus.READ ? din_cw : enc_cw;
        s1_synd <= bus.READ ? hsyn(din_cw) : '0;
        s1_par  <= bus.READ & (^din_cw);
      end
    end
  end

  // A syndrome beyond the codeword with odd parity cannot be a single error.
  assign in_range = 32'(s1_synd) < 32'(CW_W);
  assign ev_sec   = s1_valid & s1_read & s1_par & in_range;
  assign ev_ded   = s1_valid & s1_read & (s1_par ? !in_range : (s1_synd != '0));
  assign flip     = (s1_read & s1_par & in_range) ? (CW_W'(1) << s1_synd) : '0;
  assign corr_cw  = s1_cw ^ flip;
  assign result_next = s1_read ? BUS_W'(corr_data) : BUS_W'(corr_cw);

  // Stage 2: result register and flags; result holds across bubbles.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      result_q     <= '0;
      dout_valid_q <= 1'b0;
      sec_q        <= 1'b0;
      ded_q        <= 1'b0;
    end else begin
      dout_valid_q <= s1_valid;
      sec_q        <= ev_sec;
      ded_q        <= ev_ded;
      if (s1_valid) result_q <= result_next;
    end
  end

  // Saturating counters and sticky flags; an event coincident with clear survives.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sec_cnt    <= '0;
      ded_cnt    <= '0;
      sticky_sec <= 1'b0;
      sticky_ded <= 1'b0;
    end else if (bus.clr_cnt) begin
      sec_cnt    <= CNT_W'(ev_sec);
      ded_cnt    <= CNT_W'(ev_ded);
      sticky_sec <= ev_sec;
      sticky_ded <= ev_ded;
    end else begin
      if (ev_sec && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_W'(1);
      if (ev_ded && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
      sticky_sec <= sticky_sec | ev_sec;
      sticky_ded <= sticky_ded | ev_ded;
    end
  end

`ifdef EDAC_SYND_CAPTURE_EN
  logic [P-1:0] synd_q;
  logic         first_err;

  // Both sticky flags clear means no error has been seen since reset/clear.
  assign first_err = (ev_sec | ev_ded) & (bus.clr_cnt | !(sticky_sec | sticky_ded));

  // Syndrome capture: first error only, later errors leave it alone.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      synd_q <= '0;
    end else if (first_err) begin
      synd_q <= s1_synd;
    end else if (bus.clr_cnt) begin
      synd_q <= '0;
    end
  end
`endif

  // Status word assembly from registered sources.
  always_comb begin
    status                   = '0;
    status[CNT_W-1:0]        = sec_cnt;
    status[2*CNT_W-1:CNT_W]  = ded_cnt;
    status[16]               = sticky_sec;
    status[17]               = sticky_ded;
`ifdef EDAC_SYND_CAPTURE_EN
    status[24 +: P]          = synd_q;
`endif
  end

  assign bus.DOUT       = bus.EDACSEL ? result_q : status;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sec        = sec_q;
  assign bus.ded        = ded_q;

endmodule

// File: tb/tb_edac_secded_pipe.sv
// tb_edac_secded_pipe: directed vectors with hand-computed codewords and
// status words for the DATA_W=8 configuration.
module tb_edac_secded_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  edac_secded_pipe_if #(.BUS_W(32)) bus ();

  edac_secded_pipe #(.DATA_W(8), .BUS_W(32), .CNT_W(8)) dut (
    .CLK   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

`ifdef EDAC_SYND_CAPTURE_EN
  localparam logic [3:0] SYN9 = 4'd9;
`else
  localparam logic [3:0] SYN9 = 4'd0;
`endif

  function automatic logic [31:0] st(input logic [7:0] sc, input logic [7:0] dc,
                                     input logic ss, input logic sd, input logic [3:0] syn);
    return {4'b0, syn, 6'b0, sd, ss, dc, sc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(output logic [31:0] s);
    bus.EDACSEL = 1'b0;
    #1;
    s = bus.DOUT;
    bus.EDACSEL = 1'b1;
    #1;
  endtask

  task automatic do_op(input logic rd, input logic [31:0] d);
    bus.en   = 1'b1;
    bus.READ = rd;
    bus.DIN  = d;
    step();
    bus.en   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] s;
    rst_n = 1'b0;
    step();
    n_vec++;
    if (bus.DOUT !== 32'h0 || bus.dout_valid !== 1'b0 || bus.sec !== 1'b0 || bus.ded !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: dout=%h valid=%b sec=%b ded=%b, required 0/0/0/0",
               bus.DOUT, bus.dout_valid, bus.sec, bus.ded);
    end
    read_status(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status: got %h, required 00000000", s);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_encode();
    logic [31:0] din_t [4] = '{32'h0000_00F4, 32'h0000_00FF, 32'h0000_0001, 32'h00AB_CD01};
    logic [31:0] exp_t [4] = '{32'h0000_1E44, 32'h0000_1EEE, 32'h0000_000F, 32'h0000_000F};
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, din_t[i]);
      n_vec++;
      if (bus.dout_valid !== 1'b1 || bus.DOUT !== exp_t[i] || bus.sec !== 1'b0 || bus.ded !== 1'b0) begin
        n_err++;
        $display("FAIL encode_%0d: valid=%b dout=%h sec=%b ded=%b, required 1 %h 0 0",
                 i, bus.dout_valid, bus.DOUT, bus.sec, bus.ded, exp_t[i]);
      end
    end
    read_status(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL encode_status: got %h, required 00000000", s);
    end
  endtask

  task automatic test_clean_decode();
    logic [31:0] s;
    do_op(1'b1, 32'h0000_1E44);
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00F4 || bus.sec !== 1'b0 || bus.ded !== 1'b0) begin
      n_err++;
      $display("FAIL clean_decode: valid=%b dout=%h sec=%b ded=%b, required 1 000000f4 0 0",
               bus.dout_valid, bus.DOUT, bus.sec, bus.ded);
    end
    step();
    n_vec++;
    if (bus.dout_valid !== 1'b0 || bus.DOUT !== 32'h0000_00F4) begin
      n_err++;
      $display("FAIL bubble_hold: valid=%b dout=%h, required 0 000000f4", bus.dout_valid, bus.DOUT);
    end
    read_status(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL clean_status: got %h, required 00000000", s);
    end
  endtask

  task automatic test_single_error();
    logic [31:0] s;
    do_op(1'b1, 32'h0000_1C44);
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00F4 || bus.sec !== 1'b1 || bus.ded !== 1'b0) begin
      n_err++;
      $display("FAIL sec_pos9: valid=%b dout=%h sec=%b ded=%b, required 1 000000f4 1 0",
               bus.dout_valid, bus.DOUT, bus.sec, bus.ded);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'd1, 8'd0, 1'b1, 1'b0, SYN9)) begin
      n_err++;
      $display("FAIL sec_pos9_status: got %h, required %h", s, st(8'd1, 8'd0, 1'b1, 1'b0, SYN9));
    end
    do_op(1'b1, 32'h0000_1E45);
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00F4 || bus.sec !== 1'b1 || bus.ded !== 1'b0) begin
      n_err++;
      $display("FAIL sec_pos0: valid=%b dout=%h sec=%b ded=%b, required 1 000000f4 1 0",
               bus.dout_valid, bus.DOUT, bus.sec, bus.ded);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'd2, 8'd0, 1'b1, 1'b0, SYN9)) begin
      n_err++;
      $display("FAIL sec_pos0_status: got %h, required %h", s, st(8'd2, 8'd0, 1'b1, 1'b0, SYN9));
    end
  endtask

  task automatic test_double_error();
    logic [31:0] s;
    do_op(1'b1, 32'h0000_1C40);
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00E4 || bus.sec !== 1'b0 || bus.ded !== 1'b1) begin
      n_err++;
      $display("FAIL ded_even: valid=%b dout=%h sec=%b ded=%b, required 1 000000e4 0 1",
               bus.dout_valid, bus.DOUT, bus.sec, bus.ded);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'd2, 8'd1, 1'b1, 1'b1, SYN9)) begin
      n_err++;
      $display("FAIL ded_even_status: got %h, required %h", s, st(8'd2, 8'd1, 1'b1, 1'b1, SYN9));
    end
    // Positions 1,4,8 flipped: syndrome 13 lies past the codeword, parity odd.
    do_op(1'b1, 32'h0000_1F56);
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00F4 || bus.sec !== 1'b0 || bus.ded !== 1'b1) begin
      n_err++;
      $display("FAIL ded_range: valid=%b dout=%h sec=%b ded=%b, required 1 000000f4 0 1",
               bus.dout_valid, bus.DOUT, bus.sec, bus.ded);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'd2, 8'd2, 1'b1, 1'b1, SYN9)) begin
      n_err++;
      $display("FAIL ded_range_status: got %h, required %h", s, st(8'd2, 8'd2, 1'b1, 1'b1, SYN9));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    bus.en   = 1'b1;
    bus.READ = 1'b1;
    bus.DIN  = 32'h0000_1C44;
    step();
    for (int i = 0; i < 300; i++) begin
      if (i == 299) bus.en = 1'b0;
      step();
      n_vec++;
      if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_00F4 || bus.sec !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_cycle_%0d: valid=%b dout=%h sec=%b, required 1 000000f4 1",
                 i, bus.dout_valid, bus.DOUT, bus.sec);
      end
    end
    step();
    n_vec++;
    if (bus.dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: valid=%b, required 0", bus.dout_valid);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'hFF, 8'd2, 1'b1, 1'b1, SYN9)) begin
      n_err++;
      $display("FAIL b2b_saturate: got %h, required %h", s, st(8'hFF, 8'd2, 1'b1, 1'b1, SYN9));
    end
  endtask

  task automatic test_clear();
    logic [31:0] s;
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    read_status(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL clear_plain: got %h, required 00000000", s);
    end
    bus.en   = 1'b1;
    bus.READ = 1'b1;
    bus.DIN  = 32'h0000_1C44;
    step();
    bus.en      = 1'b0;
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.sec !== 1'b1 || bus.DOUT !== 32'h0000_00F4) begin
      n_err++;
      $display("FAIL clear_event_out: valid=%b sec=%b dout=%h, required 1 1 000000f4",
               bus.dout_valid, bus.sec, bus.DOUT);
    end
    read_status(s);
    n_vec++;
    if (s !== st(8'd1, 8'd0, 1'b1, 1'b0, SYN9)) begin
      n_err++;
      $display("FAIL clear_event_status: got %h, required %h", s, st(8'd1, 8'd0, 1'b1, 1'b0, SYN9));
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] s;
    bus.en   = 1'b1;
    bus.READ = 1'b0;
    bus.DIN  = 32'h0000_00FF;
    step();
    bus.DIN = 32'h0000_0001;
    step();
    n_vec++;
    if (bus.dout_valid !== 1'b1 || bus.DOUT !== 32'h0000_1EEE) begin
      n_err++;
      $display("FAIL midstream_first: valid=%b dout=%h, required 1 00001eee", bus.dout_valid, bus.DOUT);
    end
    bus.en = 1'b0;
    rst_n  = 1'b0;
    step();
    n_vec++;
    if (bus.DOUT !== 32'h0 || bus.dout_valid !== 1'b0 || bus.sec !== 1'b0 || bus.ded !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_reset: dout=%h valid=%b sec=%b ded=%b, required 0/0/0/0",
               bus.DOUT, bus.dout_valid, bus.sec, bus.ded);
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (bus.dout_valid !== 1'b0 || bus.DOUT !== 32'h0) begin
      n_err++;
      $display("FAIL midstream_dropped: valid=%b dout=%h, required 0 00000000", bus.dout_valid, bus.DOUT);
    end
    read_status(s);
    n_vec++;
    if (s !== 32'h0) begin
      n_err++;
      $display("FAIL midstream_status: got %h, required 00000000", s);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.READ    = 1'b0;
    bus.EDACSEL = 1'b1;
    bus.clr_cnt = 1'b0;
    bus.DIN     = 32'h0;
    test_reset();
    test_encode();
    test_clean_decode();
    test_single_error();
    test_double_error();
    test_back_to_back();
    test_clear();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
